// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master byte memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int DEFAULT_READ_LATENCY = 2;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector; i_last=1 means master 1 owned the bus last.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // On a tie the master opposite the last owner wins.
    always_comb begin
        o_grant = GRANT_NONE;
        case (i_req)
            2'b01:   o_grant = GRANT_M0;
            2'b10:   o_grant = GRANT_M1;
            2'b11: begin
                if (i_last) begin
                    o_grant = GRANT_M0;
                end else begin
                    o_grant = GRANT_M1;
                end
            end
            default: o_grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port byte memory with a fixed pipelined read latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                  clock,
    input  logic                  locked,
    input  logic                  i_m0_req,
    input  logic                  i_m0_we,
    input  logic [ADDR_WIDTH-1:0] i_m0_address,
    input  logic [7:0]            i_m0_data,
    output logic [7:0]            o_m0_data,
    output logic                  o_m0_ack,
    input  logic                  i_m1_req,
    input  logic                  i_m1_we,
    input  logic [ADDR_WIDTH-1:0] i_m1_address,
    input  logic [7:0]            i_m1_data,
    output logic [7:0]            o_m1_data,
    output logic                  o_m1_ack,
    output logic [ADDR_WIDTH-1:0] o_address,
    input  logic [7:0]            i_data,
    output logic [7:0]            o_data,
    output logic                  o_we,
    output logic [1:0]            o_grant
);

    localparam int                CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(READ_LATENCY);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic [1:0]         w_pick;

    rr_pick2 u_pick (
        .i_req   ({i_m1_req, i_m0_req}),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    // Bus FSM: grant, write strobe, read latency count, data capture and ack pulse.
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            o_we      <= 1'b0;
            o_address <= '0;
            o_data    <= 8'h00;
            o_grant   <= GRANT_NONE;
            o_m0_ack  <= 1'b0;
            o_m1_ack  <= 1'b0;
            o_m0_data <= 8'h00;
            o_m1_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt    <= '0;
                    o_m0_ack <= 1'b0;
                    o_m1_ack <= 1'b0;
                    if (w_pick == GRANT_M0) begin
                        o_we      <= i_m0_we;
                        o_address <= i_m0_address;
                        o_data    <= i_m0_data;
                        o_grant   <= GRANT_M0;
                        r_last    <= 1'b0;
                        r_state   <= i_m0_we ? ST_WRITE : ST_READ;
                    end else if (w_pick == GRANT_M1) begin
                        o_we      <= i_m1_we;
                        o_address <= i_m1_address;
                        o_data    <= i_m1_data;
                        o_grant   <= GRANT_M1;
                        r_last    <= 1'b1;
                        r_state   <= i_m1_we ? ST_WRITE : ST_READ;
                    end else begin
                        o_we    <= 1'b0;
                        o_grant <= GRANT_NONE;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    o_we     <= 1'b0;
                    o_m0_ack <= o_grant[0];
                    o_m1_ack <= o_grant[1];
                    r_state  <= ST_ACK;
                end
                ST_READ: begin
                    o_we <= 1'b0;
                    // Memory data for our address is on i_data during the final count cycle.
                    if (r_cnt == CNT_LAST) begin
                        if (o_grant[0]) begin
                            o_m0_data <= i_data;
                        end else begin
                            o_m0_data <= o_m0_data;
                        end
                        if (o_grant[1]) begin
                            o_m1_data <= i_data;
                        end else begin
                            o_m1_data <= o_m1_data;
                        end
                        o_m0_ack <= o_grant[0];
                        o_m1_ack <= o_grant[1];
                        r_state  <= ST_ACK;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_ACK: begin
                    o_we     <= 1'b0;
                    o_m0_ack <= 1'b0;
                    o_m1_ack <= 1'b0;
                    o_grant  <= GRANT_NONE;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    o_we     <= 1'b0;
                    o_m0_ack <= 1'b0;
                    o_m1_ack <= 1'b0;
                    o_grant  <= GRANT_NONE;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed table, reset/contention sequences, READ_LATENCY=3 build, random run vs. a cycle-budget model.
module tb_mem_arbiter;

    localparam int RL = 2;

    logic clock  = 1'b0;
    logic locked = 1'b0;
    always #5 clock = ~clock;

    logic        i_m0_req = 1'b0, i_m0_we = 1'b0, i_m1_req = 1'b0, i_m1_we = 1'b0;
    logic [31:0] i_m0_address = 32'h0, i_m1_address = 32'h0;
    logic [7:0]  i_m0_data = 8'h00, i_m1_data = 8'h00;
    logic [7:0]  o_m0_data, o_m1_data, i_data, o_data;
    logic        o_m0_ack, o_m1_ack, o_we;
    logic [31:0] o_address;
    logic [1:0]  o_grant;

    logic        r3_req = 1'b0;
    logic [7:0]  u3_d0, u3_d1, u3_idata, u3_odata;
    logic        u3_ack0, u3_ack1, u3_we;
    logic [31:0] u3_address;
    logic [1:0]  u3_grant;

    mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(RL)) dut (
        .clock(clock), .locked(locked),
        .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_address(i_m0_address), .i_m0_data(i_m0_data),
        .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack),
        .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_address(i_m1_address), .i_m1_data(i_m1_data),
        .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack),
        .o_address(o_address), .i_data(i_data), .o_data(o_data), .o_we(o_we), .o_grant(o_grant)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clock(clock), .locked(locked),
        .i_m0_req(1'b0), .i_m0_we(1'b0), .i_m0_address(32'h0), .i_m0_data(8'h00),
        .o_m0_data(u3_d0), .o_m0_ack(u3_ack0),
        .i_m1_req(r3_req), .i_m1_we(1'b0), .i_m1_address(32'h0000_0055), .i_m1_data(8'h00),
        .o_m1_data(u3_d1), .o_m1_ack(u3_ack1),
        .o_address(u3_address), .i_data(u3_idata), .o_data(u3_odata), .o_we(u3_we), .o_grant(u3_grant)
    );

    // Pipelined RAM models: read data appears READ_LATENCY cycles after the address.
    logic [7:0]  ram  [0:65535];
    logic [31:0] pipe_a [0:RL-1];
    logic [7:0]  ram3 [0:255];
    logic [31:0] pipe3 [0:2];

    always @(posedge clock) begin
        pipe_a[0] <= o_address;
        for (int k = 1; k < RL; k++) pipe_a[k] <= pipe_a[k-1];
        if (o_we) ram[o_address[15:0]] <= o_data;
        pipe3[0] <= u3_address;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign i_data   = ram[pipe_a[RL-1][15:0]];
    assign u3_idata = ram3[pipe3[2][7:0]];

    // Reference memory contents: written bytes, else the preload pattern.
    logic [7:0] ref_mem [bit [15:0]];
    function automatic logic [7:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a[15:0])) return ref_mem[a[15:0]];
        return a[7:0] ^ 8'h5A;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a, input logic [7:0] d);
        if (m == 0) begin
            i_m0_req = req; i_m0_we = we; i_m0_address = a; i_m0_data = d;
        end else begin
            i_m1_req = req; i_m1_we = we; i_m1_address = a; i_m1_data = d;
        end
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t vec [7];

    int          got_lat, we_cnt, n_acks, w;
    logic [7:0]  got_dat;
    int          free_at, ack_at, grant_at, owner;
    logic        last_g, cur_we;
    logic        pend [2];
    logic        pwe  [2];
    logic [31:0] paddr [2];
    logic [7:0]  pdat [2];
    logic [7:0]  exp_rd;
    logic [7:0]  exp_od [2];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 256; i++) ram3[i] = 8'h00;
        ram3[8'h55] = 8'hC3;
        ram[16'h0100] = 8'h3C;
        ref_mem[16'h0100] = 8'h3C;

        vec[0] = '{0, 1'b1, 32'h0000_1234, 8'hA5, 8'h00, 2};
        vec[1] = '{1, 1'b0, 32'h0000_0100, 8'h00, 8'h3C, RL + 2};
        vec[2] = '{0, 1'b1, 32'h0000_0040, 8'h77, 8'h00, 2};
        vec[3] = '{1, 1'b0, 32'h0000_0040, 8'h00, 8'h77, RL + 2};
        vec[4] = '{0, 1'b0, 32'h0000_1234, 8'h00, 8'hA5, RL + 2};
        vec[5] = '{1, 1'b1, 32'hDEAD_0010, 8'h11, 8'h00, 2};
        vec[6] = '{0, 1'b0, 32'h0000_0010, 8'h00, 8'h11, RL + 2};

        #2;
        chk("rst_we", 32'(o_we), 32'h0);
        chk("rst_addr", o_address, 32'h0);
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_acks", 32'({o_m1_ack, o_m0_ack}), 32'h0);
        chk("rst_mdata", 32'({o_m1_data, o_m0_data}), 32'h0);
        @(negedge clock);
        @(negedge clock);
        locked = 1'b1;

        for (int t = 0; t < 7; t++) begin
            drive(vec[t].m, 1'b1, vec[t].we, vec[t].addr, vec[t].wdata);
            got_lat = -1;
            we_cnt  = 0;
            got_dat = 8'h00;
            for (int k = 1; k <= 20 && got_lat < 0; k++) begin
                @(negedge clock);
                if (k == 1) begin
                    chk("vec_addr", o_address, vec[t].addr);
                    chk("vec_grant", 32'(o_grant), (vec[t].m == 0) ? 32'h1 : 32'h2);
                    if (vec[t].we) chk("vec_wdata", 32'(o_data), 32'(vec[t].wdata));
                end
                we_cnt += int'(o_we);
                chk("vec_twoacks", 32'(o_m0_ack & o_m1_ack), 32'h0);
                if ((vec[t].m == 0) ? o_m0_ack : o_m1_ack) begin
                    got_lat = k;
                    got_dat = (vec[t].m == 0) ? o_m0_data : o_m1_data;
                    drive(vec[t].m, 1'b0, 1'b0, 32'h0, 8'h00);
                end
            end
            drive(vec[t].m, 1'b0, 1'b0, 32'h0, 8'h00);
            chk("vec_latency", got_lat, vec[t].exp_lat);
            chk("vec_strobes", we_cnt, vec[t].we ? 1 : 0);
            if (vec[t].we) ref_mem[vec[t].addr[15:0]] = vec[t].wdata;
            else chk("vec_rdata", 32'(got_dat), 32'(vec[t].exp_rd));
            @(negedge clock);
            chk("vec_idle_grant", 32'(o_grant), 32'h0);
        end
        chk("ram_1234", 32'(ram[16'h1234]), 32'hA5);

        // Reset in the middle of a read: nothing must complete.
        drive(0, 1'b1, 1'b0, 32'h0000_0100, 8'h00);
        @(negedge clock);
        @(negedge clock);
        locked = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00);
        #1;
        chk("mid_rst_we", 32'(o_we), 32'h0);
        chk("mid_rst_grant", 32'(o_grant), 32'h0);
        chk("mid_rst_addr", o_address, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("mid_rst_noack", 32'({o_m1_ack, o_m0_ack}), 32'h0);
        end
        locked = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("post_rst_idle", 32'({o_grant, o_m1_ack, o_m0_ack}), 32'h0);
        end

        // Both masters continuously reading: strict alternation starting with m0.
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 8'h00);
        drive(1, 1'b1, 1'b0, 32'h0000_0020, 8'h00);
        n_acks = 0;
        for (int k = 1; k <= 40 && n_acks < 4; k++) begin
            @(negedge clock);
            if (k == 1) chk("tie_grant", 32'(o_grant), 32'h1);
            chk("rr_twoacks", 32'(o_m0_ack & o_m1_ack), 32'h0);
            if (o_m0_ack || o_m1_ack) begin
                w = o_m1_ack ? 1 : 0;
                chk("rr_order", w, n_acks % 2);
                chk("rr_data", 32'((w == 1) ? o_m1_data : o_m0_data),
                    32'(ref_read((w == 1) ? 32'h20 : 32'h10)));
                n_acks++;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00);
        drive(1, 1'b0, 1'b0, 32'h0, 8'h00);
        chk("rr_count", n_acks, 4);

        // READ_LATENCY=3 instance: ack at T5 with the third-cycle byte.
        @(negedge clock);
        @(negedge clock);
        r3_req  = 1'b1;
        got_lat = -1;
        got_dat = 8'h00;
        for (int k = 1; k <= 20 && got_lat < 0; k++) begin
            @(negedge clock);
            if (k == 1) chk("rl3_grant", 32'(u3_grant), 32'h2);
            chk("rl3_no_m0", 32'({u3_ack0, u3_we}), 32'h0);
            if (u3_ack1) begin
                got_lat = k;
                got_dat = u3_d1;
                r3_req  = 1'b0;
            end
        end
        r3_req = 1'b0;
        chk("rl3_latency", got_lat, 5);
        chk("rl3_data", 32'(got_dat), 32'hC3);
        chk("rl3_other", 32'({u3_d0, u3_odata}), 32'h0);

        // Random traffic against a cycle-budget transaction model.
        locked = 1'b0;
        @(negedge clock);
        @(negedge clock);
        locked   = 1'b1;
        free_at  = 0;
        ack_at   = -1;
        grant_at = -1;
        owner    = 0;
        last_g   = 1'b1;
        cur_we   = 1'b0;
        exp_rd   = 8'h00;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; pwe[m] = 1'b0; paddr[m] = 32'h0; pdat[m] = 8'h00; exp_od[m] = 8'h00;
        end
        for (int n = 0; n < 300; n++) begin
            if (n == ack_at && !cur_we) exp_od[owner] = exp_rd;
            chk("rnd_ack0", 32'(o_m0_ack), 32'(n == ack_at && owner == 0));
            chk("rnd_ack1", 32'(o_m1_ack), 32'(n == ack_at && owner == 1));
            chk("rnd_grant", 32'(o_grant), (n > grant_at && n <= ack_at) ? ((owner == 0) ? 32'h1 : 32'h2) : 32'h0);
            chk("rnd_data0", 32'(o_m0_data), 32'(exp_od[0]));
            chk("rnd_data1", 32'(o_m1_data), 32'(exp_od[1]));
            if (n == ack_at) pend[owner] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 3) != 0) begin
                    pend[m]  = 1'b1;
                    pwe[m]   = 1'($urandom_range(0, 1));
                    paddr[m] = 32'h0000_0200 + 32'($urandom_range(0, 7));
                    pdat[m]  = 8'($urandom);
                end
            end
            drive(0, pend[0], pwe[0], paddr[0], pdat[0]);
            drive(1, pend[1], pwe[1], paddr[1], pdat[1]);
            if (n >= free_at && (pend[0] || pend[1])) begin
                owner    = (pend[0] && pend[1]) ? (last_g ? 0 : 1) : (pend[0] ? 0 : 1);
                last_g   = (owner == 1);
                grant_at = n;
                cur_we   = pwe[owner];
                ack_at   = n + (cur_we ? 2 : RL + 2);
                free_at  = ack_at + 1;
                if (cur_we) ref_mem[paddr[owner][15:0]] = pdat[owner];
                else exp_rd = ref_read(paddr[owner]);
            end
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port byte memory bus (32-bit address, 8-bit data, one write strobe, fixed pipelined read latency) between two requesters.
- Master 0 is the x86cpu core. Master 1 is a DMA/video fetch engine.
- Sits between the masters and the RAM. Converts per-master req/ack handshakes into correctly timed memory bus cycles.
- Uses round-robin fairness.

Parameters:
- ADDR_WIDTH, 32, width of every address bus.
- READ_LATENCY, 2, cycles from address presented to i_data valid; must be ≥1.

Ports:
- clock  in  1  system clock, all logic on rising edge
- locked  in  1  asynchronous active-low reset (0 = reset, 1 = run)
- i_m0_req  in  1  master 0 request, held until ack
- i_m0_we  in  1  master 0 write (1) / read (0)
- i_m0_address  in  ADDR_WIDTH  master 0 byte address
- i_m0_data  in  8  master 0 write data
- o_m0_data  out  8  master 0 read data, valid with ack
- o_m0_ack  out  1  master 0 completion pulse
- i_m1_req, i_m1_we, i_m1_address, i_m1_data, o_m1_data, o_m1_ack  same as master 0
- o_address  out  ADDR_WIDTH  memory address
- i_data  in  8  memory read data, READ_LATENCY cycles after address
- o_data  out  8  memory write data
- o_we  out  1  memory write strobe
- o_grant  out  2  one-hot current owner, 00 when idle

Behaviour:
- Reset (locked=0, asynchronous), forced immediately:
  - state=IDLE, o_we=0, o_address=0, o_data=0.
  - o_m*_ack=0, o_m*_data=0, o_grant=00, last-grant pointer=1 (so master 0 wins the first tie).
  - A transfer in flight is abandoned with no ack.
- All outputs are registered.
- States: IDLE, WRITE, READ, ACK.
- IDLE:
  - Samples requests.
  - If exactly one req is high, that master is granted.
  - If both are high, the master opposite the last-grant pointer is granted.
  - On grant: latch that master's we/address/data into o_we/o_address/o_data, set o_grant, update the pointer, and go to WRITE (we=1) or READ (we=0).
  - With no req, stay in IDLE; o_we=0 and o_address/o_data hold.
- WRITE:
  - o_we=1 for exactly this one cycle.
  - Next state ACK; o_we returns to 0.
- READ:
  - Address held stable, o_we=0.
  - Counter runs 0..READ_LATENCY.
  - On the edge ending the cycle where counter==READ_LATENCY, capture i_data into the granted master's o_m*_data, then go to ACK.
- ACK:
  - Granted master's o_m*_ack=1 for exactly one cycle.
  - Next state IDLE, with o_grant=00 in IDLE.
- Latency from req first seen in IDLE:
  - Write: ack 2 cycles later (T0 grant, T1 strobe, T2 ack).
  - Read: ack READ_LATENCY+2 cycles later (4 for default).
- Master contract:
  - Request inputs are sampled only in IDLE; changes during a transfer are ignored.
  - A master drops or replaces req on the edge where it samples ack. The arbiter does not mask, so a req still high in IDLE is a new transfer.
  - Back-to-back requests by one master get one IDLE cycle between transfers.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- o_m*_data of the non-granted master holds its previous value. Never two acks in one cycle.
- Address arithmetic: pass-through, no wrap or truncation; the memory decodes the low bits.

Decomposition:
- Package mem_arbiter_pkg:
  - State enum (IDLE, WRITE, READ, ACK), 2-bit.
  - Grant encodings GRANT_NONE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10.
  - Default READ_LATENCY constant.
- Optional sub-module rr_pick2: combinational 2-way round-robin selector (inputs req[1:0], last; output grant one-hot). The FSM, latency counter and capture registers stay in mem_arbiter.

Test Plan:
- Reset/idle: locked=0 mid-read (READ, counter=1) → o_we=0, o_grant=00, no ack ever issued. Release → IDLE; master 0 wins the first tie.
- Single write: m0 req we=1 addr 0x00001234 data 0xA5 → o_we=1 for one cycle with o_address=0x00001234, o_data=0xA5; o_m0_ack at T2; RAM[0x1234]=0xA5.
- Single read: preload RAM[0x00000100]=0x3C, m1 read → o_address held 3 cycles, o_we=0, o_m1_data=0x3C with o_m1_ack at T4.
- Contention: both req continuously, m0 reads 0x10, m1 reads 0x20 → grants alternate 0,1,0,1 starting with m0. Each ack carries the correct byte; never two acks in the same cycle.
- Read-after-write, different masters: m0 writes 0x77 to 0x40, then m1 reads 0x40 → m1 gets 0x77.
- READ_LATENCY=3 build: single read → ack at T5; data captured from the correct (3rd-cycle) i_data, not the stale preceding value.
